// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of several one-cycle-latency FIFOs into a single valid/ready stream.
// Each beat takes a READ/WAIT/PRESENT pass; a grant lasts at most BURST_LEN beats.
module fifo_drain_arbiter #(
    parameter int number_ports    = 4,
    parameter int FIFO_DATA_WIDTH = 18,
    parameter int BURST_LEN       = 4
) (
    input  logic                                    clk_out,
    input  logic                                    reset,
    input  logic [number_ports-1:0]                 fifo_empty,
    input  logic [FIFO_DATA_WIDTH*number_ports-1:0] fifo_data,
    output logic [number_ports-1:0]                 fifo_read_en,
    output logic [FIFO_DATA_WIDTH-1:0]              m_data,
    output logic [7:0]                              m_port,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic                                    m_last,
    output logic                                    busy
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, PRESENT} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 grant_q, grant_d;
    logic [7:0]                 lastGrant_q, lastGrant_d;
    logic [7:0]                 beatCnt_q, beatCnt_d;
    logic [number_ports-1:0]    readEn_q, readEn_d;
    logic [FIFO_DATA_WIDTH-1:0] mData_q, mData_d;
    logic [7:0]                 mPort_q, mPort_d;
    logic                       mValid_q, mValid_d;
    logic                       mLast_q, mLast_d;

    logic                       found;
    logic [7:0]                 foundIdx;
    logic [8:0]                 searchOff;
    logic [8:0]                 bestOff;
    logic                       grantEmpty;
    logic [FIFO_DATA_WIDTH-1:0] grantData;
    logic                       readReq;
    logic [7:0]                 readIdx;

    // Rotating priority: each port's distance from lastGrant+1 (mod N); nearest non-empty port wins.
    always_comb begin
        found     = 1'b0;
        foundIdx  = '0;
        bestOff   = '1;
        searchOff = '0;
        for (int p = 0; p < number_ports; p++) begin
            searchOff = 9'(p + number_ports - 1) - {1'b0, lastGrant_q};
            if (searchOff >= 9'(number_ports)) begin
                searchOff = searchOff - 9'(number_ports);
            end
            if (!fifo_empty[p] && (searchOff < bestOff)) begin
                bestOff  = searchOff;
                foundIdx = 8'(p);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        grantEmpty = 1'b1;
        grantData  = '0;
        for (int p = 0; p < number_ports; p++) begin
            if (grant_q == 8'(p)) begin
                grantEmpty = fifo_empty[p];
                grantData  = fifo_data[FIFO_DATA_WIDTH*p +: FIFO_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        beatCnt_d   = beatCnt_q;
        mData_d     = mData_q;
        mPort_d     = mPort_q;
        mValid_d    = mValid_q;
        mLast_d     = mLast_q;
        readReq     = 1'b0;
        readIdx     = grant_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = foundIdx;
                    beatCnt_d = '0;
                    readReq   = 1'b1;
                    readIdx   = foundIdx;
                    state_d   = READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                mData_d  = grantData;
                mPort_d  = grant_q;
                mLast_d  = (beatCnt_q == 8'(BURST_LEN - 1));
                mValid_d = 1'b1;
                state_d  = PRESENT;
            end
            PRESENT: begin
                if (mValid_q && m_ready) begin
                    mValid_d  = 1'b0;
                    mLast_d   = 1'b0;
                    beatCnt_d = beatCnt_q + 8'd1;
                    // Burst ends on full length or when the granted FIFO has run dry.
                    if ((beatCnt_q + 8'd1 == 8'(BURST_LEN)) || grantEmpty) begin
                        lastGrant_d = grant_q;
                        state_d     = IDLE;
                    end else begin
                        readReq = 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        readEn_d = '0;
        for (int p = 0; p < number_ports; p++) begin
            readEn_d[p] = readReq && (readIdx == 8'(p));
        end
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            lastGrant_q <= 8'(number_ports - 1);
            beatCnt_q   <= '0;
            readEn_q    <= '0;
            mData_q     <= '0;
            mPort_q     <= '0;
            mValid_q    <= 1'b0;
            mLast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            beatCnt_q   <= beatCnt_d;
            readEn_q    <= readEn_d;
            mData_q     <= mData_d;
            mPort_q     <= mPort_d;
            mValid_q    <= mValid_d;
            mLast_q     <= mLast_d;
        end
    end

    assign fifo_read_en = readEn_q;
    assign m_data       = mData_q;
    assign m_port       = mPort_q;
    assign m_valid      = mValid_q;
    assign m_last       = mLast_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural one-cycle-latency FIFOs per port and a
// scoreboard of expected {port, data, last} beats checked on every handshake.
module tb_fifo_drain_arbiter;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int BL = 4;

    logic           clk_out = 1'b0;
    logic           reset;
    logic [N-1:0]   fifo_empty;
    logic [W*N-1:0] fifo_data;
    logic [N-1:0]   fifo_read_en;
    logic [W-1:0]   m_data;
    logic [7:0]     m_port;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           busy;

    logic [W-1:0] mem [N][32];
    logic [4:0]   rdPtr [N]   = '{default: '0};
    logic [4:0]   wrPtr [N]   = '{default: '0};
    logic [W-1:0] dataReg [N] = '{default: '0};

    logic [8+W:0] sbQ [$];
    logic [8+W:0] expBeat;
    int checksTotal  = 0;
    int checksPassed = 0;
    int protoErrors  = 0;

    fifo_drain_arbiter #(
        .number_ports   (N),
        .FIFO_DATA_WIDTH(W),
        .BURST_LEN      (BL)
    ) dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .m_data      (m_data),
        .m_port      (m_port),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .busy        (busy)
    );

    always #5 clk_out = ~clk_out;

    always_comb begin
        fifo_empty = '0;
        fifo_data  = '0;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]       = (rdPtr[i] == wrPtr[i]);
            fifo_data[W*i +: W] = dataReg[i];
        end
    end

    // FIFO model: a read strobe presents the head word one cycle later.
    always @(posedge clk_out) begin
        for (int i = 0; i < N; i++) begin
            if (fifo_read_en[i] && (rdPtr[i] != wrPtr[i])) begin
                dataReg[i] <= mem[i][rdPtr[i]];
                rdPtr[i]   <= rdPtr[i] + 5'd1;
            end
        end
    end

    // Every accepted beat must be the oldest outstanding expectation.
    always @(negedge clk_out) begin
        if (!reset) begin
            if (($countones(fifo_read_en) > 1) || ((fifo_read_en != '0) && m_valid) ||
                ((fifo_read_en & fifo_empty) != '0)) begin
                protoErrors++;
            end
            if (m_valid && m_ready) begin
                checksTotal++;
                if (sbQ.size() == 0) begin
                    $display("[TB] FAIL beat_unexpected: got port=%0d data=%h last=%b, required no beat",
                             m_port, m_data, m_last);
                end else begin
                    expBeat = sbQ.pop_front();
                    if ({m_port, m_data, m_last} !== expBeat) begin
                        $display("[TB] FAIL beat_order: got port=%0d data=%h last=%b, required port=%0d data=%h last=%b",
                                 m_port, m_data, m_last, expBeat[8+W:W+1], expBeat[W:1], expBeat[0]);
                    end else begin
                        checksPassed++;
                    end
                end
            end
        end
    end

    task automatic loadWord(input int port, input logic [W-1:0] word);
        mem[port][wrPtr[port]] = word;
        wrPtr[port] = wrPtr[port] + 5'd1;
    endtask

    function automatic void expectBeat(input int port, input logic [W-1:0] word, input logic last);
        sbQ.push_back({8'(port), word, last});
    endfunction

    task automatic flushAll();
        for (int i = 0; i < N; i++) wrPtr[i] = rdPtr[i];
    endtask

    task automatic waitValid(input int maxCycles, output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk_out);
            if (m_valid) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic waitDrain(input int maxCycles, output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < maxCycles; c++) begin
            @(negedge clk_out);
            if ((sbQ.size() == 0) && !busy) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < N; p++) loadWord(p, W'(32'h100 + p));
        @(posedge clk_out); #1;
        @(negedge clk_out);
        checksTotal++;
        if ({fifo_read_en, m_valid, m_last, m_data, m_port, busy} !== '0)
            $display("[TB] FAIL reset_during: got read_en=%b valid=%b last=%b data=%h port=%0d busy=%b, required all 0",
                     fifo_read_en, m_valid, m_last, m_data, m_port, busy);
        else checksPassed++;
        @(posedge clk_out); #1;
        reset = 1'b0;
        @(negedge clk_out);
        checksTotal++;
        if ({fifo_read_en, m_valid, m_last, m_data, m_port, busy} !== '0)
            $display("[TB] FAIL reset_after: got read_en=%b valid=%b last=%b data=%h port=%0d busy=%b, required all 0",
                     fifo_read_en, m_valid, m_last, m_data, m_port, busy);
        else checksPassed++;
        @(negedge clk_out);
        checksTotal++;
        if (fifo_read_en !== 4'b0001)
            $display("[TB] FAIL reset_first_read: got %b, required 0001", fifo_read_en);
        else checksPassed++;
        checksTotal++;
        if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b, required 1", busy);
        else checksPassed++;
        @(posedge clk_out); #1;
        reset = 1'b1;
        flushAll();
        @(posedge clk_out); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_port();
        int  pos [8];
        int  nPulse = 0;
        bit  done   = 1'b0;
        m_ready = 1'b1;
        expectBeat(0, 18'h0A, 1'b0);
        expectBeat(0, 18'h0B, 1'b0);
        expectBeat(0, 18'h0C, 1'b0);
        loadWord(0, 18'h0A);
        loadWord(0, 18'h0B);
        loadWord(0, 18'h0C);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_out);
            if (fifo_read_en != '0) begin
                checksTotal++;
                if (fifo_read_en !== 4'b0001)
                    $display("[TB] FAIL single_read_target: got %b, required 0001", fifo_read_en);
                else checksPassed++;
                if (nPulse < 8) pos[nPulse] = c;
                nPulse++;
            end
            if ((sbQ.size() == 0) && !busy) done = 1'b1;
        end
        checksTotal++;
        if (!done) $display("[TB] FAIL single_timeout: got busy=%b pending=%0d, required idle and drained", busy, sbQ.size());
        else checksPassed++;
        checksTotal++;
        if (nPulse != 3) $display("[TB] FAIL single_pulse_count: got %0d, required 3", nPulse);
        else checksPassed++;
        checksTotal++;
        if (!((nPulse >= 3) && (pos[1] - pos[0] == 3) && (pos[2] - pos[1] == 3)))
            $display("[TB] FAIL single_pulse_spacing: got gaps %0d,%0d, required 3,3", pos[1] - pos[0], pos[2] - pos[1]);
        else checksPassed++;
        @(negedge clk_out);
        checksTotal++;
        if ({busy, fifo_read_en} !== 5'b0)
            $display("[TB] FAIL single_idle: got busy=%b read_en=%b, required 0 and 0000", busy, fifo_read_en);
        else checksPassed++;
    endtask

    task automatic test_round_robin();
        bit to;
        @(posedge clk_out); #1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) expectBeat(1, W'(32'h100 + k), k == 3);
        for (int k = 0; k < 4; k++) expectBeat(3, W'(32'h300 + k), k == 3);
        for (int k = 4; k < 6; k++) expectBeat(1, W'(32'h100 + k), 1'b0);
        for (int k = 4; k < 6; k++) expectBeat(3, W'(32'h300 + k), 1'b0);
        for (int k = 0; k < 6; k++) begin
            loadWord(1, W'(32'h100 + k));
            loadWord(3, W'(32'h300 + k));
        end
        waitDrain(300, to);
        checksTotal++;
        if (to) $display("[TB] FAIL rr_timeout: got pending=%0d busy=%b, required 0 and 0", sbQ.size(), busy);
        else checksPassed++;
        checksTotal++;
        if (fifo_empty !== 4'hF) $display("[TB] FAIL rr_fifos_drained: got empty=%b, required 1111", fifo_empty);
        else checksPassed++;
    endtask

    task automatic test_backpressure();
        bit to;
        @(posedge clk_out); #1;
        m_ready = 1'b0;
        expectBeat(2, 18'h2AA, 1'b0);
        loadWord(2, 18'h2AA);
        waitValid(20, to);
        checksTotal++;
        if (to) $display("[TB] FAIL bp_valid_timeout: got valid=%b, required 1", m_valid);
        else checksPassed++;
        for (int i = 0; i < 5; i++) begin
            checksTotal++;
            if ({m_valid, m_port, m_data, fifo_read_en} !== {1'b1, 8'd2, 18'h2AA, 4'b0000})
                $display("[TB] FAIL bp_hold: got valid=%b port=%0d data=%h read_en=%b, required 1 2 2aa 0000",
                         m_valid, m_port, m_data, fifo_read_en);
            else checksPassed++;
            @(negedge clk_out);
        end
        @(posedge clk_out); #1;
        m_ready = 1'b1;
        @(negedge clk_out);
        @(negedge clk_out);
        checksTotal++;
        if ({m_valid, busy} !== 2'b00)
            $display("[TB] FAIL bp_release: got valid=%b busy=%b, required 0 0", m_valid, busy);
        else checksPassed++;
        waitDrain(20, to);
        checksTotal++;
        if (to) $display("[TB] FAIL bp_drain: got pending=%0d, required 0", sbQ.size());
        else checksPassed++;
    endtask

    task automatic test_wrap();
        bit to;
        @(posedge clk_out); #1;
        m_ready = 1'b1;
        expectBeat(3, 18'h3A1, 1'b0);
        loadWord(3, 18'h3A1);
        waitDrain(40, to);
        checksTotal++;
        if (to) $display("[TB] FAIL wrap_setup: got pending=%0d, required 0", sbQ.size());
        else checksPassed++;
        @(posedge clk_out); #1;
        expectBeat(0, 18'h0A2, 1'b0);
        expectBeat(3, 18'h3A2, 1'b0);
        loadWord(0, 18'h0A2);
        loadWord(3, 18'h3A2);
        waitDrain(60, to);
        checksTotal++;
        if (to) $display("[TB] FAIL wrap_drain: got pending=%0d, required 0", sbQ.size());
        else checksPassed++;
    endtask

    task automatic test_reset_mid();
        bit to;
        @(posedge clk_out); #1;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) loadWord(2, W'(32'h2B0 + k));
        expectBeat(2, 18'h2B0, 1'b0);
        waitValid(20, to);
        checksTotal++;
        if (to) $display("[TB] FAIL mid_beat1_timeout: got valid=%b, required 1", m_valid);
        else checksPassed++;
        @(posedge clk_out); #1;
        m_ready = 1'b1;
        @(posedge clk_out); #1;
        m_ready = 1'b0;
        waitValid(20, to);
        checksTotal++;
        if (to || ({m_port, m_data} !== {8'd2, 18'h2B1}))
            $display("[TB] FAIL mid_beat2_held: got valid=%b port=%0d data=%h, required 1 2 2b1", m_valid, m_port, m_data);
        else checksPassed++;
        @(posedge clk_out); #1;
        reset = 1'b1;
        loadWord(0, 18'h0F0);
        expectBeat(0, 18'h0F0, 1'b0);
        expectBeat(2, 18'h2B2, 1'b0);
        expectBeat(2, 18'h2B3, 1'b0);
        @(posedge clk_out); #1;
        reset   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk_out);
        checksTotal++;
        if ({m_valid, fifo_read_en, m_data, busy} !== '0)
            $display("[TB] FAIL mid_reset_cleared: got valid=%b read_en=%b data=%h busy=%b, required all 0",
                     m_valid, fifo_read_en, m_data, busy);
        else checksPassed++;
        @(negedge clk_out);
        checksTotal++;
        if (fifo_read_en !== 4'b0001)
            $display("[TB] FAIL mid_restart_port0: got %b, required 0001", fifo_read_en);
        else checksPassed++;
        waitDrain(80, to);
        checksTotal++;
        if (to) $display("[TB] FAIL mid_drain: got pending=%0d busy=%b, required 0 0", sbQ.size(), busy);
        else checksPassed++;
    endtask

    initial begin
        reset   = 1'b1;
        m_ready = 1'b0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        checksTotal++;
        if (protoErrors != 0)
            $display("[TB] FAIL read_strobe_protocol: got %0d violations, required 0", protoErrors);
        else checksPassed++;
        checksTotal++;
        if (sbQ.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d pending, required 0", sbQ.size());
        else checksPassed++;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
